game_data: RTL
==============

GAME_DATA -- requirements
Module: game_data

Interface
REQ-001 SHALL have parameter CLK_HZ, default 1000; cycles of clk per game second.
REQ-002 SHALL have parameter GAME_TIME, default 60; countdown start value in seconds, legal range 1..99.
REQ-003 SHALL have parameter SCORE_MAX, default 99; score saturation ceiling.
REQ-004 SHALL have port clk, input, 1 bit; sole clock, 1 kHz, all logic rising-edge.
REQ-005 SHALL have port rst, input, 1 bit; synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit; single-cycle pulse that begins a game.
REQ-007 SHALL have port hit, input, 1 bit; single-cycle pulse for a valid mole hit.
REQ-008 SHALL have port miss, input, 1 bit; single-cycle pulse for a wrong press (penalty).
REQ-009 SHALL have port score_out, output, 7 bits; registered score, 0..SCORE_MAX, to the display driver.
REQ-010 SHALL have port time_out, output, 7 bits; registered seconds remaining, 0..GAME_TIME, to the display driver.
REQ-011 SHALL have port playing, output, 1 bit; high only in PLAY.
REQ-012 SHALL have port game_over, output, 1 bit; high only in OVER.

Function
REQ-013 SHALL implement FSM states IDLE, PLAY and OVER.
REQ-014 SHALL, in IDLE, hold score_out=0 and time_out=GAME_TIME and ignore hit/miss; start moves it to PLAY on the next edge.
REQ-015 SHALL, on entering PLAY, load score 0, time GAME_TIME and prescaler 0 in the same edge as the state change.
REQ-016 SHALL, in PLAY, count the prescaler 0..CLK_HZ-1 and assert a one-cycle second tick at CLK_HZ-1, then wrap to 0.
REQ-017 SHALL decrement time_out by 1 on each tick; the tick that takes time_out from 1 to 0 moves the FSM to OVER on the same edge.
REQ-018 SHALL increment the score on hit in PLAY, saturating at SCORE_MAX.
REQ-019 SHALL decrement the score on miss in PLAY, saturating at 0.
REQ-020 SHALL leave the score unchanged when hit and miss are high in the same cycle.
REQ-021 SHALL apply a hit/miss coinciding with the final tick, so that a score update and the transition to OVER occur on the same edge.
REQ-022 SHALL update score_out/time_out one cycle after the causing input or tick; there is no combinational path from inputs to outputs.
REQ-023 SHALL ignore start while in PLAY.
REQ-024 SHALL, in OVER, freeze score_out, hold time_out=0 and ignore hit/miss; start re-enters PLAY per REQ-015.
REQ-025 SHALL never let score_out or time_out exceed 99, so two decimal digits always suffice.

Reset
REQ-026 SHALL, with rst high at a clk edge, set state IDLE, score_out=0, time_out=GAME_TIME, prescaler 0, playing=0 and game_over=0.
REQ-027 SHALL give rst priority over start, hit and miss in the same cycle, including mid-game, with no residual state.

Structure
REQ-028 SHALL place the state encoding (IDLE=0, PLAY=1, OVER=2), the value-width constant (7) and the SCORE_MAX default in shared package game_pkg.
REQ-029 SHALL implement the prescaler as sub-module tick_gen, with ports clk, rst, en and clear, producing a one-cycle tick every CLK_HZ enabled cycles.

Verification (CLK_HZ=4, GAME_TIME=3)
REQ-030 SHALL cover this scenario: reset then start -> playing=1 next cycle, time_out 3->2->1->0 at 4-cycle intervals, and game_over=1 on the edge time_out reaches 0.
REQ-031 SHALL cover this scenario: in PLAY, 101 hit pulses -> score_out saturates at 99; then 1 miss -> 98.
REQ-032 SHALL cover this scenario: miss at score 0 -> score stays 0; simultaneous hit+miss at score 5 -> score stays 5.
REQ-033 SHALL cover this scenario: hit on the final-tick cycle at score 7 -> score_out=8, time_out=0 and game_over=1 on the same edge; later hits leave 8.
REQ-034 SHALL cover this scenario: rst asserted mid-game at score 12, time 2 -> next cycle IDLE, score 0, time 3, playing=0.
REQ-035 SHALL cover this scenario: start in OVER -> PLAY, score 0, time 3; start pulsed in PLAY -> no change to time or score.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared definitions for the whack-a-mole game data path.
//               FSM state encoding, display value width, default score
//               ceiling and a helper that clamps values to two decimal digits.
// Revision    : 1.0  initial release
// ============================================================================
package game_pkg;

    // Width of every value sent to the two-digit display driver.
    localparam int VALUE_W = 7;

    // Default score ceiling.
    localparam int SCORE_MAX_DEFAULT = 99;

    // Largest value two decimal digits can show.
    localparam int DISPLAY_MAX = 99;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        OVER = 2'd2
    } state_t;

    // Clamp a parameter value into the displayable range 0..DISPLAY_MAX.
    function automatic int clamp_display(input int value);
        if (value > DISPLAY_MAX) begin
            return DISPLAY_MAX;
        end else if (value < 0) begin
            return 0;
        end
        return value;
    endfunction

endpackage : game_pkg
`default_nettype wire

// File: rtl/tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tick_gen
// Description : Game-second prescaler. Counts enabled cycles 0..CLK_HZ-1 and
//               raises tick for the one cycle in which the count sits at
//               CLK_HZ-1; the count then wraps to 0.
// Ports       : clk   - rising-edge clock
//               rst   - synchronous active-high reset (count -> 0)
//               en    - count enable (high while a game is running)
//               clear - synchronous restart of the count at 0
//               tick  - one-cycle pulse every CLK_HZ enabled cycles
// Revision    : 1.0  initial release
// ============================================================================
module tick_gen #(
    parameter int CLK_HZ = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == c_last);
    assign tick      = en && w_at_last;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : tick_gen
`default_nettype wire

// File: rtl/game_data.sv
`default_nettype none
// ============================================================================
// Module      : game_data
// Description : Score and countdown keeper for the whack-a-mole game.
//               IDLE -> PLAY on start; PLAY counts seconds down from
//               GAME_TIME and moves to OVER on the tick that reaches 0.
//               Hits raise and misses lower the score (saturating).
// Ports       : clk       - rising-edge clock (CLK_HZ cycles per second)
//               rst       - synchronous active-high reset
//               start     - pulse: begin a game (from IDLE or OVER)
//               hit       - pulse: valid mole hit (+1)
//               miss      - pulse: wrong press (-1)
//               score_out - registered score 0..SCORE_MAX
//               time_out  - registered seconds remaining 0..GAME_TIME
//               playing   - high only in PLAY
//               game_over - high only in OVER
// Revision    : 1.0  initial release
// ============================================================================
module game_data
    import game_pkg::*;
#(
    parameter int CLK_HZ    = 1000,
    parameter int GAME_TIME = 60,
    parameter int SCORE_MAX = SCORE_MAX_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               hit,
    input  logic               miss,
    output logic [VALUE_W-1:0] score_out,
    output logic [VALUE_W-1:0] time_out,
    output logic               playing,
    output logic               game_over
);

    // Both limits are clamped so neither display value can exceed two digits,
    // whatever the parameters are set to.
    localparam logic [VALUE_W-1:0] c_score_cap = VALUE_W'(clamp_display(SCORE_MAX));
    localparam logic [VALUE_W-1:0] c_game_time = VALUE_W'(clamp_display(GAME_TIME));

    state_t             r_state;
    logic [VALUE_W-1:0] r_score;
    logic [VALUE_W-1:0] r_time;
    logic               r_playing;
    logic               r_game_over;

    logic w_tick;
    logic w_launch;
    logic w_up;
    logic w_down;

    // A start outside PLAY launches a game; the prescaler restarts on the
    // same edge so the first second is a full CLK_HZ cycles long.
    assign w_launch = start && (r_state != PLAY);

    // Simultaneous hit and miss cancel out.
    assign w_up   = hit && !miss;
    assign w_down = miss && !hit;

    tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .clk   (clk),
        .rst   (rst),
        .en    (r_state == PLAY),
        .clear (w_launch),
        .tick  (w_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_score     <= '0;
            r_time      <= c_game_time;
            r_playing   <= 1'b0;
            r_game_over <= 1'b0;
        end else begin
            case (r_state)
                IDLE, OVER: begin
                    if (start) begin
                        r_state     <= PLAY;
                        r_score     <= '0;
                        r_time      <= c_game_time;
                        r_playing   <= 1'b1;
                        r_game_over <= 1'b0;
                    end
                end

                PLAY: begin
                    // Score updates still apply on the final tick edge.
                    if (w_up && (r_score < c_score_cap)) begin
                        r_score <= r_score + 1'b1;
                    end else if (w_down && (r_score != '0)) begin
                        r_score <= r_score - 1'b1;
                    end

                    if (w_tick) begin
                        r_time <= r_time - 1'b1;
                        if (r_time == VALUE_W'(1)) begin
                            r_state     <= OVER;
                            r_playing   <= 1'b0;
                            r_game_over <= 1'b1;
                        end
                    end
                end

                default: begin
                    r_state     <= IDLE;
                    r_score     <= '0;
                    r_time      <= c_game_time;
                    r_playing   <= 1'b0;
                    r_game_over <= 1'b0;
                end
            endcase
        end
    end

    assign score_out = r_score;
    assign time_out  = r_time;
    assign playing   = r_playing;
    assign game_over = r_game_over;

endmodule : game_data
`default_nettype wire
